alu_seq: RTL
============

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (legal: 8..64, even).
REQ-002 SHALL have parameter SHAMT_W, default $clog2(XLEN), shift-amount width taken from b.
REQ-003 Port clk  in  1  single clock; all state on rising edge.
REQ-004 Port rst  in  1  reset, asynchronous, active-high.
REQ-005 Port in_valid  in  1  operation offered.
REQ-006 Port in_ready  out  1  block accepts operation this cycle.
REQ-007 Port a  in  XLEN  operand A.
REQ-008 Port b  in  XLEN  operand B.
REQ-009 Port alu_ctrl  in  4  opcode (package encoding).
REQ-010 Port flush  in  1  abort any in-flight operation.
REQ-011 Port out_valid  out  1  result held valid.
REQ-012 Port out_ready  in  1  consumer takes result.
REQ-013 Port y  out  XLEN  registered result.
REQ-014 Port zero  out  1  registered, high when y == 0.
REQ-015 Port err  out  1  registered, high when opcode illegal or disabled.

Function
REQ-016 Opcodes SHALL be: ADD 0000, SUB 0001, AND 0010, OR 0011, SLL 0100, SRL 0101, SRA 0110, XOR 0111, SLT 1000, SLTU 1001, MUL 1010, MULHU 1011, DIV 1100, DIVU 1101, REM 1110, REMU 1111.
REQ-017 Transfer SHALL occur on edge with in_valid && in_ready; out transfer on out_valid && out_ready.
REQ-018 FSM states SHALL be IDLE, BUSY, DONE; IDLE->DONE on accepted single-cycle op, IDLE->BUSY on accepted MUL/DIV class, BUSY->DONE after final iteration, DONE->IDLE on out transfer without new accept.
REQ-019 in_ready SHALL be high in IDLE, and in DONE when out_ready is high (back-to-back accept, DONE->DONE or DONE->BUSY).
REQ-020 Single-cycle ops (0000-1001) SHALL give out_valid the cycle after accept (latency 1).
REQ-021 MUL/DIV class SHALL be radix-2 iterative, fixed latency XLEN+1 cycles accept-to-out_valid, independent of operand values.
REQ-022 Arithmetic SHALL wrap modulo 2^XLEN; shifts use b[SHAMT_W-1:0] only; SRA sign-fills; SLT signed, SLTU unsigned, result 0 or 1.
REQ-023 MUL SHALL return low XLEN bits; MULHU high XLEN bits of unsigned product.
REQ-024 Divide by zero SHALL give quotient all-ones, remainder = a, err low.
REQ-025 DIV/REM with a = most-negative, b = -1 SHALL give quotient = a, remainder 0.
REQ-026 y, zero, err SHALL hold stable while out_valid && !out_ready.
REQ-027 Illegal/disabled opcode SHALL complete in 1 cycle with y=0, zero=1, err=1.
REQ-028 flush SHALL force IDLE next edge from any state, drop result, deassert out_valid; flush wins over simultaneous accept.

Reset
REQ-029 rst SHALL immediately set state IDLE, out_valid 0, y 0, zero 1, err 0, iteration counter 0.
REQ-030 rst mid-BUSY SHALL discard the operation; no out_valid after rst release until new accept.

Configuration
REQ-031 Macro ALU_SEQ_MULDIV_EN defined SHALL include the iterative MUL/DIV datapath per REQ-021..025.
REQ-032 Macro absent SHALL remove the datapath and BUSY state entirely; opcodes 1010-1111 treated as illegal per REQ-027.

Structure
REQ-033 Package alu_seq_pkg SHALL hold opcode localparams, FSM state typedef, and opcode-class helper (is_muldiv).
REQ-034 Iterative datapath SHALL be sub-module alu_muldiv_seq (start, op, a, b -> done, result), instantiated only under ALU_SEQ_MULDIV_EN.
REQ-035 Single-cycle ops SHALL be combinational in alu_seq feeding the result register.

Verification
REQ-036 ADD a=0xFFFFFFFF b=1, out_ready=1 -> out_valid next cycle, y=0, zero=1.
REQ-037 SRA a=0x80000000 b=0x24 (shamt 4) -> y=0xF8000000; SLTU a=1 b=0xFFFFFFFF -> y=1.
REQ-038 DIV a=0x80000000 b=0xFFFFFFFF -> after 33 cycles y=0x80000000; DIVU a=7 b=0 -> y=0xFFFFFFFF, err=0.
REQ-039 out_ready=0 for 5 cycles after result -> y/out_valid stable, in_ready low; then out_ready=1 with in_valid=1 -> back-to-back accept same edge.
REQ-040 flush (and separately rst) at cycle 10 of MUL -> out_valid never asserts for it; next ADD 2+3 -> y=5.
REQ-041 Build without ALU_SEQ_MULDIV_EN, issue MUL -> 1-cycle result, y=0, err=1.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Opcode encodings, FSM state type and opcode classification shared by alu_seq.
// ALU_SEQ_MULDIV_EN adds the BUSY state used by the iterative multiply/divide path.
package alu_seq_pkg;

   localparam int unsigned OP_W = 4;

   localparam logic [OP_W-1:0] OP_ADD   = 4'b0000;
   localparam logic [OP_W-1:0] OP_SUB   = 4'b0001;
   localparam logic [OP_W-1:0] OP_AND   = 4'b0010;
   localparam logic [OP_W-1:0] OP_OR    = 4'b0011;
   localparam logic [OP_W-1:0] OP_SLL   = 4'b0100;
   localparam logic [OP_W-1:0] OP_SRL   = 4'b0101;
   localparam logic [OP_W-1:0] OP_SRA   = 4'b0110;
   localparam logic [OP_W-1:0] OP_XOR   = 4'b0111;
   localparam logic [OP_W-1:0] OP_SLT   = 4'b1000;
   localparam logic [OP_W-1:0] OP_SLTU  = 4'b1001;
   localparam logic [OP_W-1:0] OP_MUL   = 4'b1010;
   localparam logic [OP_W-1:0] OP_MULHU = 4'b1011;
   localparam logic [OP_W-1:0] OP_DIV   = 4'b1100;
   localparam logic [OP_W-1:0] OP_DIVU  = 4'b1101;
   localparam logic [OP_W-1:0] OP_REM   = 4'b1110;
   localparam logic [OP_W-1:0] OP_REMU  = 4'b1111;

`ifdef ALU_SEQ_MULDIV_EN
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

   // Opcodes 1010..1111 belong to the multi-cycle multiply/divide class.
   function automatic logic is_muldiv(input logic [OP_W-1:0] op);
      return op[3] && (op[2] || op[1]);
   endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Radix-2 iterative multiply/divide unit: one bit per cycle, XLEN iterations after start.
// done and result are combinational on the final iteration so the caller can register them.
module alu_muldiv_seq
   import alu_seq_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            start,
   input  logic [OP_W-1:0] op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int unsigned CNT_W = $clog2(XLEN);

   logic             r_busy;
   logic [CNT_W-1:0] r_cnt;
   logic [XLEN-1:0]  r_hi;
   logic [XLEN-1:0]  r_lo;
   logic [XLEN-1:0]  r_opd;
   logic [OP_W-1:0]  r_op;
   logic             r_negq;
   logic             r_negr;

   logic            w_is_div;
   logic            w_sgn;
   logic            w_a_neg;
   logic            w_b_neg;
   logic [XLEN-1:0] w_a_mag;
   logic [XLEN-1:0] w_b_mag;
   logic [XLEN:0]   w_sum;
   logic [XLEN:0]   w_rsh;
   logic [XLEN+1:0] w_diff;
   logic            w_qbit;
   logic [XLEN-1:0] w_hi_n;
   logic [XLEN-1:0] w_lo_n;

   // Signed divide works on magnitudes; signs are restored on the way out.
   assign w_is_div = op[2];
   assign w_sgn    = w_is_div && !op[0];
   assign w_a_neg  = w_sgn && a[XLEN-1];
   assign w_b_neg  = w_sgn && b[XLEN-1];
   assign w_a_mag  = w_a_neg ? -a : a;
   assign w_b_mag  = w_b_neg ? -b : b;

   // Shift-add multiply: {hi,lo} accumulates product, lo starts as multiplier.
   assign w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opd} : {(XLEN+1){1'b0}});
   // Restoring divide: hi is partial remainder, lo shifts dividend out and quotient in.
   assign w_rsh  = {r_hi, r_lo[XLEN-1]};
   assign w_diff = {1'b0, w_rsh} - {2'b00, r_opd};
   assign w_qbit = !w_diff[XLEN+1];

   always_comb begin
      w_hi_n = w_sum[XLEN:1];
      w_lo_n = {w_sum[0], r_lo[XLEN-1:1]};
      if (r_op[2]) begin
         w_hi_n = w_qbit ? w_diff[XLEN-1:0] : w_rsh[XLEN-1:0];
         w_lo_n = {r_lo[XLEN-2:0], w_qbit};
      end
   end

   assign done = r_busy && (r_cnt == CNT_W'(XLEN - 1));

   always_comb begin
      result = '0;
      case (r_op)
         OP_MUL:   result = w_lo_n;
         OP_MULHU: result = w_hi_n;
         OP_DIV:   result = r_negq ? -w_lo_n : w_lo_n;
         OP_DIVU:  result = w_lo_n;
         OP_REM:   result = r_negr ? -w_hi_n : w_hi_n;
         OP_REMU:  result = w_hi_n;
         default:  result = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy <= 1'b0;
         r_cnt  <= '0;
         r_hi   <= '0;
         r_lo   <= '0;
         r_opd  <= '0;
         r_op   <= OP_MUL;
         r_negq <= 1'b0;
         r_negr <= 1'b0;
      end else if (flush) begin
         r_busy <= 1'b0;
         r_cnt  <= '0;
      end else if (start) begin
         r_busy <= 1'b1;
         r_cnt  <= '0;
         r_hi   <= '0;
         r_lo   <= w_is_div ? w_a_mag : b;
         r_opd  <= w_is_div ? w_b_mag : a;
         r_op   <= op;
         // Divide by zero keeps an unsigned all-ones quotient regardless of sign.
         r_negq <= (w_a_neg ^ w_b_neg) && (b != '0);
         r_negr <= w_a_neg;
      end else if (r_busy) begin
         r_hi  <= w_hi_n;
         r_lo  <= w_lo_n;
         r_cnt <= r_cnt + CNT_W'(1);
         if (done) begin
            r_busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes: single-cycle ops plus optional
// iterative MUL/DIV class enabled by the ALU_SEQ_MULDIV_EN macro.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned SHAMT_W = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [OP_W-1:0] alu_ctrl,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] y,
   output logic            zero,
   output logic            err
);

   state_t          r_state;
   logic            r_out_valid;
   logic [XLEN-1:0] r_y;
   logic            r_zero;
   logic            r_err;

   logic               w_accept;
   logic [SHAMT_W-1:0] w_shamt;
   logic [XLEN-1:0]    w_sc_y;
   logic               w_sc_err;

   assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
   assign w_accept  = in_valid && in_ready;
   assign w_shamt   = b[SHAMT_W-1:0];
   assign out_valid = r_out_valid;
   assign y         = r_y;
   assign zero      = r_zero;
   assign err       = r_err;

   // Single-cycle datapath; anything not handled here is illegal or disabled.
   always_comb begin
      w_sc_y   = '0;
      w_sc_err = 1'b0;
      case (alu_ctrl)
         OP_ADD:  w_sc_y = a + b;
         OP_SUB:  w_sc_y = a - b;
         OP_AND:  w_sc_y = a & b;
         OP_OR:   w_sc_y = a | b;
         OP_SLL:  w_sc_y = a << w_shamt;
         OP_SRL:  w_sc_y = a >> w_shamt;
         OP_SRA:  w_sc_y = XLEN'($signed(a) >>> w_shamt);
         OP_XOR:  w_sc_y = a ^ b;
         OP_SLT:  w_sc_y = XLEN'($signed(a) < $signed(b));
         OP_SLTU: w_sc_y = XLEN'(a < b);
         default: w_sc_err = 1'b1;
      endcase
   end

`ifdef ALU_SEQ_MULDIV_EN
   logic            w_is_md;
   logic            w_md_start;
   logic            w_md_done;
   logic [XLEN-1:0] w_md_result;

   assign w_is_md    = is_muldiv(alu_ctrl);
   assign w_md_start = w_accept && w_is_md && !flush;

   alu_muldiv_seq #(
      .XLEN (XLEN)
   ) u_muldiv (
      .clk    (clk),
      .rst    (rst),
      .flush  (flush),
      .start  (w_md_start),
      .op     (alu_ctrl),
      .a      (a),
      .b      (b),
      .done   (w_md_done),
      .result (w_md_result)
   );
`endif

   // Control FSM; flush outranks any accept on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_out_valid <= 1'b0;
         r_y         <= '0;
         r_zero      <= 1'b1;
         r_err       <= 1'b0;
      end else if (flush) begin
         r_state     <= IDLE;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (w_accept) begin
`ifdef ALU_SEQ_MULDIV_EN
                  if (w_is_md) begin
                     r_state     <= BUSY;
                     r_out_valid <= 1'b0;
                  end else
`endif
                  begin
                     r_state     <= DONE;
                     r_out_valid <= 1'b1;
                     r_y         <= w_sc_y;
                     r_zero      <= (w_sc_y == '0);
                     r_err       <= w_sc_err;
                  end
               end else if ((r_state == DONE) && out_ready) begin
                  r_state     <= IDLE;
                  r_out_valid <= 1'b0;
               end
            end
`ifdef ALU_SEQ_MULDIV_EN
            BUSY: begin
               if (w_md_done) begin
                  r_state     <= DONE;
                  r_out_valid <= 1'b1;
                  r_y         <= w_md_result;
                  r_zero      <= (w_md_result == '0);
                  r_err       <= 1'b0;
               end
            end
`endif
            default: begin
               r_state     <= IDLE;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
